// File: rtl/point_rotator.sv
// Rotates a signed point about the origin using magnitudes from an external
// registered sine/cosine table; quadrant signs are applied from the angle index.
module point_rotator #(
   parameter int COORD_W = 11,
   parameter int SCALE   = 1000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [COORD_W-1:0] x_in,
   input  logic signed [COORD_W-1:0] y_in,
   input  logic [5:0]                angle,
   output logic [5:0]                lut_index,
   input  logic [31:0]               lut_sine,
   input  logic [31:0]               lut_cosine,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [COORD_W-1:0] x_out,
   output logic signed [COORD_W-1:0] y_out,
   output logic [2:0]                dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both 1; valid and its data stay stable until then, ready may change freely.

   localparam int MAG_W  = 11;
   localparam int PROD_W = 2 * COORD_W + 1;
   localparam int SUM_W  = PROD_W + 1;
   localparam logic signed [SUM_W-1:0] SCALE_S = SUM_W'(SCALE);
   localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((1 << (COORD_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(1 << (COORD_W - 1)));

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LUT  = 3'd1,
      CAPT = 3'd2,
      MUL  = 3'd3,
      DIV  = 3'd4,
      OUT  = 3'd5
   } state_t;

   state_t                     state_q;
   logic [5:0]                 angle_q;
   logic signed [COORD_W-1:0]  x_q, y_q;
   logic signed [MAG_W:0]      s_q, c_q;
   logic signed [PROD_W-1:0]   p_xc_q, p_ys_q, p_xs_q, p_yc_q;

   logic [5:0]                 angle_d;
   logic signed [MAG_W:0]      s_mag, c_mag, s_d, c_d;
   logic signed [PROD_W-1:0]   x_e, y_e, s_e, c_e;
   logic signed [SUM_W-1:0]    xsum, ysum, xquo, yquo;
   logic signed [COORD_W-1:0]  x_d, y_d;

   // Only the low magnitude bits of the table words carry information.
   logic unused_lut_bits;
   assign unused_lut_bits = ^{lut_sine[31:MAG_W], lut_cosine[31:MAG_W]};

   function automatic logic signed [COORD_W-1:0] sat(input logic signed [SUM_W-1:0] v);
      if (v > OUT_MAX)      return COORD_W'(OUT_MAX);
      else if (v < OUT_MIN) return COORD_W'(OUT_MIN);
      else                  return COORD_W'(v);
   endfunction

   always_comb begin
      angle_d = ((angle == 6'd0) || (angle > 6'd61)) ? 6'd1 : angle;
      s_mag   = $signed({1'b0, lut_sine[MAG_W-1:0]});
      c_mag   = $signed({1'b0, lut_cosine[MAG_W-1:0]});
      // Sine is negative in the third/fourth quadrants, cosine in the second/third.
      s_d     = ((angle_q >= 6'd32) && (angle_q <= 6'd60)) ? -s_mag : s_mag;
      c_d     = ((angle_q >= 6'd17) && (angle_q <= 6'd45)) ? -c_mag : c_mag;
      x_e     = PROD_W'(x_q);
      y_e     = PROD_W'(y_q);
      s_e     = PROD_W'(s_q);
      c_e     = PROD_W'(c_q);
      xsum    = SUM_W'(p_xc_q) - SUM_W'(p_ys_q);
      ysum    = SUM_W'(p_xs_q) + SUM_W'(p_yc_q);
      // Signed division truncates toward zero.
      xquo    = xsum / SCALE_S;
      yquo    = ysum / SCALE_S;
      x_d     = sat(xquo);
      y_d     = sat(yquo);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         x_out     <= '0;
         y_out     <= '0;
         lut_index <= 6'd1;
         angle_q   <= '0;
         x_q       <= '0;
         y_q       <= '0;
         s_q       <= '0;
         c_q       <= '0;
         p_xc_q    <= '0;
         p_ys_q    <= '0;
         p_xs_q    <= '0;
         p_yc_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x_q       <= x_in;
                  y_q       <= y_in;
                  angle_q   <= angle_d;
                  lut_index <= angle_d;
                  in_ready  <= 1'b0;
                  state_q   <= LUT;
               end
            end
            LUT: state_q <= CAPT;
            CAPT: begin
               s_q     <= s_d;
               c_q     <= c_d;
               state_q <= MUL;
            end
            MUL: begin
               p_xc_q  <= x_e * c_e;
               p_ys_q  <= y_e * s_e;
               p_xs_q  <= x_e * s_e;
               p_yc_q  <= y_e * c_e;
               state_q <= DIV;
            end
            DIV: begin
               x_out     <= x_d;
               y_out     <= y_d;
               out_valid <= 1'b1;
               state_q   <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_point_rotator.sv
// Directed bench for point_rotator with a registered sine/cosine table model
// holding hand-picked magnitudes for the angles exercised.
module tb_point_rotator;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic signed [10:0] x_in, y_in;
   logic [5:0]        angle;
   logic [5:0]        lut_index;
   logic [31:0]       lut_sine, lut_cosine;
   logic              out_valid;
   logic              out_ready;
   logic signed [10:0] x_out, y_out;
   logic [2:0]        dbg_state_o;

   int total = 0;
   int bad   = 0;

   point_rotator #(.COORD_W(11), .SCALE(1000)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .y_in(y_in), .angle(angle), .lut_index(lut_index),
      .lut_sine(lut_sine), .lut_cosine(lut_cosine), .out_valid(out_valid),
      .out_ready(out_ready), .x_out(x_out), .y_out(y_out),
      .dbg_state_o(dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- table model (registered, one clock) ----------------
   function automatic void table_lookup(input logic [5:0] idx, output int s, output int c);
      case (idx)
         6'd6:    begin s = 500;  c = 867;  end
         6'd8:    begin s = 670;  c = 744;  end
         6'd16:   begin s = 1000; c = 1;    end
         6'd31:   begin s = 0;    c = 1000; end
         6'd36:   begin s = 500;  c = 866;  end
         6'd46:   begin s = 1000; c = 1;    end
         default: begin s = 0;    c = 1000; end
      endcase
   endfunction

   always @(posedge clk) begin
      int s, c;
      table_lookup(lut_index, s, c);
      lut_sine   <= 32'(s);
      lut_cosine <= 32'(c);
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Accepts one point and returns once out_valid is seen (or the budget runs out).
   task automatic send_point(input int ang, input int xi, input int yi, input int eidx,
                             input string tag);
      int lat;
      in_valid = 1'b1;
      angle    = 6'(ang);
      x_in     = 11'(xi);
      y_in     = 11'(yi);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, " lut_index"}, int'(lut_index), eidx);
      check({tag, " busy"}, int'(in_ready), 0);
      // accept edge n, out_valid visible after edge n+4
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, lat, 4);
   endtask

   task automatic run_point(input int ang, input int xi, input int yi,
                            input int ex, input int ey, input int eidx, input string tag);
      out_ready = 1'b1;
      send_point(ang, xi, yi, eidx, tag);
      check({tag, " x"}, int'(x_out), ex);
      check({tag, " y"}, int'(y_out), ey);
      @(posedge clk); #1;
      check({tag, " valid drop"}, int'(out_valid), 0);
      check({tag, " ready back"}, int'(in_ready), 1);
      check({tag, " x held"}, int'(x_out), ex);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int stray;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      angle     = '0;
      x_in      = '0;
      y_in      = '0;
      #12;
      check("reset in_ready", int'(in_ready), 1);
      check("reset out_valid", int'(out_valid), 0);
      check("reset x_out", int'(x_out), 0);
      check("reset y_out", int'(y_out), 0);
      check("reset lut_index", int'(lut_index), 1);
      check("reset state", int'(dbg_state_o), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      run_point(1,  100,   50,  100,   50, 1,  "ident");
      run_point(16, 100,    0,    0,  100, 16, "rot90");
      run_point(31, 100,   50, -100,  -50, 31, "rot180");
      run_point(46, 100,    0,    0, -100, 46, "rot270");
      run_point(6,  1000,   0,  867,  500, 6,  "rot30");
      run_point(8,  1023, -1024, 1023, -76, 8, "sat_trunc");
      run_point(36, 300,  100, -209, -236, 36, "rot210");
      run_point(31, -1024,  0, 1023,    0, 31, "neg_sat");
      run_point(0,  7,    -9,    7,   -9, 1,  "ang0");
      run_point(62, 7,    -9,    7,   -9, 1,  "ang62");
      run_point(63, 7,    -9,    7,   -9, 1,  "ang63");

      // back-pressure: outputs frozen, stray in_valid ignored
      out_ready = 1'b0;
      send_point(16, 100, 0, 16, "bp");
      in_valid = 1'b1;
      angle    = 6'd1;
      x_in     = 11'sd5;
      y_in     = 11'sd5;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp valid", int'(out_valid), 1);
         check("bp x", int'(x_out), 0);
         check("bp y", int'(y_out), 100);
         check("bp in_ready", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp valid drop", int'(out_valid), 0);
      check("bp ready back", int'(in_ready), 1);

      // reset while in MUL
      run_point(6, 1000, 0, 867, 500, 6, "pre_rst");
      send_point_partial();
      check("mid state", int'(dbg_state_o), 3);
      reset = 1'b1;
      #1;
      check("mid_rst x_out", int'(x_out), 0);
      check("mid_rst y_out", int'(y_out), 0);
      check("mid_rst out_valid", int'(out_valid), 0);
      check("mid_rst in_ready", int'(in_ready), 1);
      check("mid_rst lut_index", int'(lut_index), 1);
      @(posedge clk); #1;
      reset = 1'b0;
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) stray++;
      end
      check("mid_rst no valid", stray, 0);
      run_point(31, 100, 50, -100, -50, 31, "recover");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Accept a point and stop two edges later, while the DUT sits in MUL.
   task automatic send_point_partial();
      in_valid = 1'b1;
      angle    = 6'd6;
      x_in     = 11'sd1000;
      y_in     = 11'sd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

endmodule
